// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit that owns the HI/LO register pair.
// Operands are made non-negative on entry, one bit is processed per cycle, and signs are restored in FIX.
module mult_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        mtHi,
  input  logic        mtLo,
  input  logic [31:0] mtData,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
    if (neg) begin
      return ~v + 32'd1;
    end else begin
      return v;
    end
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
    if (neg) begin
      return ~v + 64'd1;
    end else begin
      return v;
    end
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [4:0]  cnt_r;
  logic        is_div_r;
  logic        neg_q_r;
  logic        neg_r_r;
  logic        div0_r;
  logic [31:0] orig_a_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [63:0] acc_r;
  logic [31:0] rem_r;

  logic        signed_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [32:0] mul_sum_s;
  logic [32:0] div_shift_s;
  logic [32:0] div_diff_s;
  logic        qbit_s;
  logic [63:0] prod_s;
  logic [31:0] hi_fix_s;
  logic [31:0] lo_fix_s;

  // Strip signs from the incoming operands for MULT/DIV
  always_comb begin
    signed_s = ~op[0];
    abs_a_s  = cneg32(operandA, signed_s & operandA[31]);
    abs_b_s  = cneg32(operandB, signed_s & operandB[31]);
  end

  // One shift-add step (a_r multiplicand, b_r multiplier) or one restoring-divide step
  // (a_r dividend shifting out / quotient shifting in, b_r divisor)
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[63:32]} + (b_r[0] ? {1'b0, a_r} : 33'd0);
    div_shift_s = {rem_r, a_r[31]};
    div_diff_s  = div_shift_s - {1'b0, b_r};
    qbit_s      = ~div_diff_s[32];
  end

  // Sign-corrected results written to HI/LO in FIX
  always_comb begin
    prod_s   = cneg64(acc_r, neg_q_r);
    hi_fix_s = prod_s[63:32];
    lo_fix_s = prod_s[31:0];
    if (is_div_r) begin
      if (div0_r) begin
        hi_fix_s = orig_a_r;
        lo_fix_s = 32'hFFFF_FFFF;
      end else begin
        hi_fix_s = cneg32(rem_r, neg_r_r);
        lo_fix_s = cneg32(a_r, neg_q_r);
      end
    end else begin
      hi_fix_s = prod_s[63:32];
      lo_fix_s = prod_s[31:0];
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == 5'd31) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = CALC;
        end
      end
      FIX:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand latch, iteration datapath and HI/LO ownership
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r    <= 5'd0;
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      div0_r   <= 1'b0;
      orig_a_r <= 32'd0;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      acc_r    <= 64'd0;
      rem_r    <= 32'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r    <= 5'd0;
            is_div_r <= op[1];
            neg_q_r  <= signed_s & (operandA[31] ^ operandB[31]);
            neg_r_r  <= signed_s & operandA[31];
            div0_r   <= op[1] & (operandB == 32'd0);
            orig_a_r <= operandA;
            a_r      <= abs_a_s;
            b_r      <= abs_b_s;
            acc_r    <= 64'd0;
            rem_r    <= 32'd0;
          end else begin
            if (mtHi) hi <= mtData;
            if (mtLo) lo <= mtData;
          end
        end
        CALC: begin
          cnt_r <= cnt_r + 5'd1;
          if (is_div_r) begin
            rem_r <= qbit_s ? div_diff_s[31:0] : div_shift_s[31:0];
            a_r   <= {a_r[30:0], qbit_s};
          end else begin
            acc_r <= {mul_sum_s, acc_r[31:1]};
            b_r   <= {1'b0, b_r[31:1]};
          end
        end
        FIX: begin
          cnt_r <= 5'd0;
          hi    <= hi_fix_s;
          lo    <= lo_fix_s;
        end
        default: begin
          cnt_r <= 5'd0;
        end
      endcase
    end
  end

  // Registered status outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt_s != IDLE);
      done <= (state_r == FIX);
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO pushed at stimulus time, popped at done.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] operandA = 32'd0;
  logic [31:0] operandB = 32'd0;
  logic        mtHi = 1'b0;
  logic        mtLo = 1'b0;
  logic [31:0] mtData = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];

  mult_div_unit dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operandA(operandA), .operandB(operandB),
    .mtHi(mtHi), .mtLo(mtLo), .mtData(mtData),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  // Reference: {hi, lo} from plain SystemVerilog arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] qv;
    logic [63:0] rv;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'd0: return sa * sb;
      2'd1: return {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (or bound expires)
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic with_mtlo, input logic [31:0] mt_val,
                        output logic [31:0] r_hi, output logic [31:0] r_lo,
                        output int lat, output logic [31:0] lo_e0);
    op = o; operandA = a; operandB = b; start = 1'b1; mtLo = with_mtlo; mtData = mt_val;
    @(negedge clock);
    start = 1'b0; mtLo = 1'b0;
    lat = 1;
    lo_e0 = lo;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    r_hi = hi;
    r_lo = lo;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    n_tests++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_hold: busy=%b done=%b hi=%h lo=%h, required all 0", busy, done, hi, lo);
    end
    reset = 1'b1;
    @(negedge clock);
    n_tests++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b done=%b hi=%h lo=%h, required all 0", busy, done, hi, lo);
    end
  endtask

  task automatic test_multiply();
    logic [1:0]  o;
    logic [31:0] a, b, rh, rl, le0;
    logic [63:0] e;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin o = 2'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; e = 64'hFFFF_FFFE_0000_0001; end
        1: begin o = 2'd0; a = 32'hFFFF_FFFD; b = 32'd5; e = 64'hFFFF_FFFF_FFFF_FFF1; end
        default: begin o = {1'b0, i[0]}; a = $urandom; b = $urandom; e = model(o, a, b); end
      endcase
      exp_q.push_back(e);
      run_op(o, a, b, 1'b0, 32'd0, rh, rl, lat, le0);
      e = exp_q.pop_front();
      n_tests++;
      if ({rh, rl} !== e || lat != 34) begin
        n_fail++;
        $display("FAIL mul[%0d] op=%0d a=%h b=%h: got hi=%h lo=%h edges=%0d, required hi=%h lo=%h edges=34",
                 i, o, a, b, rh, rl, lat, e[63:32], e[31:0]);
      end
      @(negedge clock);
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_done_width[%0d]: done=%b busy=%b one cycle after done, required 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_divide();
    logic [1:0]  o;
    logic [31:0] a, b, rh, rl, le0;
    logic [63:0] e;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin o = 2'd3; a = 32'd7; b = 32'd2; e = {32'd1, 32'd3}; end
        1: begin o = 2'd2; a = 32'hFFFF_FFF9; b = 32'd2; e = {32'hFFFF_FFFF, 32'hFFFF_FFFD}; end
        2: begin o = 2'd2; a = 32'h8000_0000; b = 32'hFFFF_FFFF; e = {32'd0, 32'h8000_0000}; end
        default: begin
          o = {1'b1, i[0]};
          a = $urandom;
          b = ($urandom >> $urandom_range(0, 28)) | 32'd1;
          e = model(o, a, b);
        end
      endcase
      exp_q.push_back(e);
      run_op(o, a, b, 1'b0, 32'd0, rh, rl, lat, le0);
      e = exp_q.pop_front();
      n_tests++;
      if ({rh, rl} !== e || lat != 34) begin
        n_fail++;
        $display("FAIL div[%0d] op=%0d a=%h b=%h: got hi=%h lo=%h edges=%0d, required hi=%h lo=%h edges=34",
                 i, o, a, b, rh, rl, lat, e[63:32], e[31:0]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_div_zero();
    logic [1:0]  o;
    logic [31:0] a, rh, rl, le0;
    logic [63:0] e;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin o = 2'd3; a = 32'h0000_1234; e = {32'h0000_1234, 32'hFFFF_FFFF}; end
        1: begin o = 2'd2; a = 32'hFFFF_FFF0; e = {32'hFFFF_FFF0, 32'hFFFF_FFFF}; end
        default: begin o = 2'd2; a = 32'h8000_0000; e = {32'h8000_0000, 32'hFFFF_FFFF}; end
      endcase
      exp_q.push_back(e);
      run_op(o, a, 32'd0, 1'b0, 32'd0, rh, rl, lat, le0);
      e = exp_q.pop_front();
      n_tests++;
      if ({rh, rl} !== e || lat != 34) begin
        n_fail++;
        $display("FAIL div0[%0d] op=%0d a=%h: got hi=%h lo=%h edges=%0d, required hi=%h lo=%h edges=34",
                 i, o, a, rh, rl, lat, e[63:32], e[31:0]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_mt();
    logic [63:0] e;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin mtHi = 1'b1; mtData = 32'hA5A5_A5A5; e = {32'hA5A5_A5A5, lo}; end
        1: begin mtLo = 1'b1; mtData = 32'h5A5A_5A5A; e = {32'hA5A5_A5A5, 32'h5A5A_5A5A}; end
        default: begin mtHi = 1'b1; mtLo = 1'b1; mtData = 32'h1357_9BDF; e = {32'h1357_9BDF, 32'h1357_9BDF}; end
      endcase
      exp_q.push_back(e);
      @(negedge clock);
      mtHi = 1'b0; mtLo = 1'b0;
      e = exp_q.pop_front();
      n_tests++;
      if ({hi, lo} !== e) begin
        n_fail++;
        $display("FAIL mt[%0d]: got hi=%h lo=%h, required hi=%h lo=%h", i, hi, lo, e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [63:0] e;
    logic [31:0] rh, rl;
    int          lat, pulses, done_lat;
    mtHi = 1'b1; mtLo = 1'b1; mtData = 32'h1111_1111;
    @(negedge clock);
    mtHi = 1'b0; mtLo = 1'b0;
    exp_q.push_back(model(2'd0, 32'hFFFE_1DC0, 32'd789));
    op = 2'd0; operandA = 32'hFFFE_1DC0; operandB = 32'd789; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 1;
    repeat (4) begin @(negedge clock); lat++; end
    mtHi = 1'b1; mtData = 32'hDEAD_BEEF; start = 1'b1; op = 2'd1;
    operandA = 32'hFFFF_FFFF; operandB = 32'hFFFF_FFFF;
    @(negedge clock);
    lat++;
    mtHi = 1'b0; start = 1'b0;
    n_tests++;
    if (hi !== 32'h1111_1111 || lo !== 32'h1111_1111 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_hold: hi=%h lo=%h busy=%b, required hi=11111111 lo=11111111 busy=1", hi, lo, busy);
    end
    pulses = 0; done_lat = 0; rh = 32'd0; rl = 32'd0;
    while (lat < 90) begin
      if (done === 1'b1) begin
        pulses++;
        if (pulses == 1) begin rh = hi; rl = lo; done_lat = lat; end
      end
      @(negedge clock);
      lat++;
    end
    e = exp_q.pop_front();
    n_tests++;
    if (pulses != 1 || done_lat != 34 || {rh, rl} !== e) begin
      n_fail++;
      $display("FAIL busy_ignore: pulses=%0d edges=%0d hi=%h lo=%h, required pulses=1 edges=34 hi=%h lo=%h",
               pulses, done_lat, rh, rl, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_start_mtlo();
    logic [31:0] rh, rl, le0;
    logic [63:0] e;
    int          lat;
    mtLo = 1'b1; mtData = 32'h0BAD_F00D;
    @(negedge clock);
    mtLo = 1'b0;
    exp_q.push_back({32'd2, 32'd14});
    run_op(2'd3, 32'd100, 32'd7, 1'b1, 32'hCAFE_F00D, rh, rl, lat, le0);
    e = exp_q.pop_front();
    n_tests++;
    if (le0 !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL start_mtlo_drop: lo after start edge=%h, required 0badf00d", le0);
    end
    n_tests++;
    if ({rh, rl} !== e || lat != 34) begin
      n_fail++;
      $display("FAIL start_mtlo_result: hi=%h lo=%h edges=%0d, required hi=%h lo=%h edges=34",
               rh, rl, lat, e[63:32], e[31:0]);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rh, rl, le0;
    logic [63:0] e;
    int          lat;
    exp_q.push_back(model(2'd0, 32'h8000_0000, 32'h8000_0000));
    exp_q.push_back(model(2'd2, 32'hFFFF_8000, 32'd300));
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0, rh, rl, lat, le0);
    e = exp_q.pop_front();
    n_tests++;
    if ({rh, rl} !== e || lat != 34) begin
      n_fail++;
      $display("FAIL b2b_first: hi=%h lo=%h edges=%0d, required hi=%h lo=%h edges=34", rh, rl, lat, e[63:32], e[31:0]);
    end
    run_op(2'd2, 32'hFFFF_8000, 32'd300, 1'b0, 32'd0, rh, rl, lat, le0);
    e = exp_q.pop_front();
    n_tests++;
    if ({rh, rl} !== e || lat != 34) begin
      n_fail++;
      $display("FAIL b2b_second: hi=%h lo=%h edges=%0d, required hi=%h lo=%h edges=34", rh, rl, lat, e[63:32], e[31:0]);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_abort();
    logic [31:0] rh, rl, le0;
    logic [63:0] e;
    int          lat, pulses;
    mtHi = 1'b1; mtLo = 1'b1; mtData = 32'h7777_7777;
    @(negedge clock);
    mtHi = 1'b0; mtLo = 1'b0;
    op = 2'd2; operandA = 32'hFFFF_FC18; operandB = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h, required all 0", busy, done, hi, lo);
    end
    @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_abort_quiet: active cycles=%0d hi=%h lo=%h, required 0 0 0", pulses, hi, lo);
    end
    exp_q.push_back({32'd0, 32'd42});
    run_op(2'd1, 32'd6, 32'd7, 1'b0, 32'd0, rh, rl, lat, le0);
    e = exp_q.pop_front();
    n_tests++;
    if ({rh, rl} !== e || lat != 34) begin
      n_fail++;
      $display("FAIL reset_then_multu: hi=%h lo=%h edges=%0d, required hi=%h lo=%h edges=34",
               rh, rl, lat, e[63:32], e[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_div_zero();
    test_mt();
    test_busy_ignore();
    test_start_mtlo();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit owning the HI/LO register pair of the single-cycle MIPS datapath. It sits directly downstream of the register file. `operandA`/`operandB` are driven from its rs/rt read ports (readData1/readData2). It computes MULT, MULTU, DIV and DIVU one bit per cycle. Its `hi`/`lo` outputs feed the MFHI/MFLO path back into the register-file write-data mux.

## Interface
No parameters; width fixed at 32.

- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately when 0
- `start`  in  1  begin operation; sampled only in IDLE
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; latched with `start`
- `operandA`  in  32  rs value (multiplicand / dividend); latched with `start`
- `operandB`  in  32  rt value (multiplier / divisor); latched with `start`
- `mtHi`  in  1  MTHI: write `mtData` into HI; honoured only in IDLE
- `mtLo`  in  1  MTLO: write `mtData` into LO; honoured only in IDLE
- `mtData`  in  32  data for MTHI/MTLO
- `busy`  out  1  registered; 1 while an operation is in progress
- `done`  out  1  registered; one-cycle pulse when HI/LO have just been updated
- `hi`  out  32  HI register (product upper word / remainder)
- `lo`  out  32  LO register (product lower word / quotient)

## Operation
- States: IDLE, CALC, FIX. `busy` = (state != IDLE).
- Reset (`reset`=0, async): state IDLE, iteration counter 0, `busy`=0, `done`=0, `hi`=0, `lo`=0, internal operand/accumulator registers 0.
- IDLE with `start`=1: latch `op` and operands, then go to CALC with counter 0.
  - Signed ops (MULT, DIV) take absolute values of both operands and record the result sign(s).
  - `mtHi`/`mtLo` asserted on the same edge are dropped; start wins.
- IDLE with `start`=0: `mtHi` loads `hi`=`mtData`; `mtLo` loads `lo`=`mtData`. Both may be asserted together.
- CALC, multiply: unsigned shift-add over 32 multiplier bits (LSB first) into a 64-bit accumulator.
- CALC, divide: unsigned restoring division, one quotient bit per cycle (MSB first), with a 33-bit partial remainder.
- CALC: counter increments each cycle. When the counter reaches 31, the state moves to FIX.
- FIX: apply signs, write `hi`/`lo`, assert `done` for one cycle, return to IDLE.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient is negative if the operand signs differ. Remainder takes the sign of the dividend.
  - Results are truncated modulo 2^32 per word. DIV 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- Divide by zero (DIV or DIVU, `operandB`=0): `hi`=original `operandA`, `lo`=0xFFFFFFFF. Sign fix is bypassed. Latency is unchanged.
- While `busy`=1:
  - `start`, `mtHi` and `mtLo` are ignored; they are not queued.
  - `hi`/`lo` hold their previous values until FIX.
- Reset during CALC/FIX aborts the operation. No partial result is ever written to `hi`/`lo`.

## Timing
- Edge E0 samples `start`=1. `busy`=1 during cycles E0..E33.
- Edges E1..E32 perform the 32 CALC iterations.
- Edge E33 (FIX) updates `hi`/`lo` and sets `done`=1.
- After E33, `busy`=0 and `done`=1 for exactly one cycle. Result latency is 34 edges, including E0.
- A new `start` may be issued in the same cycle that `done`=1, since the unit is already IDLE.
- `done` is never asserted except on exit from FIX.
- `hi`/`lo` change only at FIX, or at an MTHI/MTLO edge in IDLE.
- MTHI/MTLO latency is one edge.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` pulse 34 edges after `start` edge. MULT −3 × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- DIVU 7 / 2 → `lo`=3, `hi`=1. DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU 0x1234 / 0 → `hi`=0x1234, `lo`=0xFFFFFFFF. DIV 0xFFFFFFF0 / 0 → `hi`=0xFFFFFFF0, `lo`=0xFFFFFFFF.
- MTHI 0xA5A5A5A5 and MTLO 0x5A5A5A5A in IDLE → values visible after one edge. During a busy MULT, assert `mtHi` and a second `start` → both ignored; only the first result appears, and `done` pulses exactly once.
- Start in the same cycle as `mtLo` in IDLE → operation runs, `mtLo` dropped. Back-to-back: a new `start` in the `done` cycle → second result arrives 34 edges later.
- Pull `reset` low at edge E10 of a DIV → `busy`, `done`, `hi`, `lo` go to 0 immediately. After release, MULTU 6 × 7 → `lo`=42, `hi`=0.
